// File: rtl/video_stream_repacker_if.sv
// Pixel stream bundle: lane-packed data, per-lane valids and line/frame markers.
interface video_stream_repacker_if #(
  parameter int PX_WIDTH   = 12,
  parameter int PX_PER_CLK = 4
);
  logic [PX_PER_CLK-1:0][PX_WIDTH-1:0] px_data;
  logic [PX_PER_CLK-1:0]               px_data_val;
  logic                                line_start;
  logic                                line_end;
  logic                                frame_start;
  logic                                frame_end;

  modport master (output px_data, px_data_val, line_start, line_end, frame_start, frame_end);
  modport slave  (input  px_data, px_data_val, line_start, line_end, frame_start, frame_end);
endinterface

// File: rtl/video_stream_repacker.sv
// Compacts sparse per-lane-valid pixel beats into dense PX_PER_CLK words and regenerates markers.
// Define VIDEO_STREAM_REPACKER_PAD_EN to replicate the last pixel into a line's unused tail lanes.
module video_stream_repacker #(
  parameter int PX_WIDTH   = 12,
  parameter int PX_PER_CLK = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  video_stream_repacker_if.slave  s_if,
  video_stream_repacker_if.master m_if,
  output logic                    err_o
);
  localparam int P  = PX_PER_CLK;
  localparam int CW = $clog2(P);

  typedef logic [PX_WIDTH-1:0] px_t;
  typedef px_t [P-1:0]         word_t;
  typedef px_t [2*P-1:0]       dword_t;
  typedef enum logic {RUN, TAIL} state_t;

  function automatic word_t shape(input word_t w, input int r);
    word_t o;
    px_t   last;
    o = '0; last = '0;
    for (int j = 0; j < P; j++) begin
      if (j < r) begin
        o[j] = w[j];
        last = w[j];
      end
`ifdef VIDEO_STREAM_REPACKER_PAD_EN
      else o[j] = last;
`endif
    end
    return o;
  endfunction

  function automatic logic [P-1:0] lane_mask(input int r);
    logic [P-1:0] m;
    for (int j = 0; j < P; j++) m[j] = (j < r);
`ifdef VIDEO_STREAM_REPACKER_PAD_EN
    m = '1;
`endif
    return m;
  endfunction

  state_t        state_q, state_d;
  word_t         res_q, res_d, tail_q, tail_d, dat_q, dat_d;
  logic [CW-1:0] cnt_q, cnt_d, tcnt_q, tcnt_d;
  logic [P-1:0]  val_q, val_d;
  logic          ls_q, ls_d, le_q, le_d, fs_q, fs_d, fe_q, fe_d;
  logic          lsp_q, lsp_d, fsp_q, fsp_d, tfe_q, tfe_d, err_q, err_d;

  dword_t buf_c;
  word_t  lo, hi;
  int     tot;
  logic   beat, ls_eff, fs_eff;

  assign beat   = |s_if.px_data_val;
  assign ls_eff = lsp_q | (beat & (s_if.line_start | s_if.frame_start));
  assign fs_eff = fsp_q | (beat & s_if.frame_start);

  // Residue followed by this beat's valid lanes in lane order.
  always_comb begin
    buf_c = '0;
    for (int i = 0; i < P; i++)
      if (i < int'(cnt_q)) buf_c[i] = res_q[i];
    tot = int'(cnt_q);
    for (int i = 0; i < P; i++) begin
      if (s_if.px_data_val[i]) begin
        for (int k = 0; k < 2*P; k++)
          if (k == tot) buf_c[k] = s_if.px_data[i];
        tot = tot + 1;
      end
    end
    for (int i = 0; i < P; i++) begin
      lo[i] = buf_c[i];
      hi[i] = buf_c[P+i];
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    tcnt_d  = tcnt_q;
    tfe_d   = tfe_q;
    lsp_d   = lsp_q;
    fsp_d   = fsp_q;
    err_d   = err_q;
    dat_d   = '0;
    val_d   = '0;
    ls_d    = 1'b0;
    le_d    = 1'b0;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    if (state_q == TAIL) begin
      // A beat landing here breaks the idle-gap contract; it is discarded whole.
      dat_d   = shape(tail_q, int'(tcnt_q));
      val_d   = lane_mask(int'(tcnt_q));
      le_d    = 1'b1;
      fe_d    = tfe_q;
      state_d = RUN;
      if (beat) err_d = 1'b1;
    end else if (beat) begin
      if (s_if.line_end && tot <= P) begin
        dat_d = shape(lo, tot);
        val_d = lane_mask(tot);
        ls_d  = ls_eff;
        fs_d  = fs_eff;
        le_d  = 1'b1;
        fe_d  = s_if.frame_end;
        cnt_d = '0;
        lsp_d = 1'b0;
        fsp_d = 1'b0;
      end else if (tot >= P) begin
        dat_d = lo;
        val_d = '1;
        ls_d  = ls_eff;
        fs_d  = fs_eff;
        lsp_d = 1'b0;
        fsp_d = 1'b0;
        res_d = hi;
        cnt_d = CW'(tot - P);
        if (s_if.line_end) begin
          tail_d  = hi;
          tcnt_d  = CW'(tot - P);
          tfe_d   = s_if.frame_end;
          cnt_d   = '0;
          state_d = TAIL;
        end
      end else begin
        res_d = lo;
        cnt_d = CW'(tot);
        lsp_d = ls_eff;
        fsp_d = fs_eff;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      res_q   <= '0;
      cnt_q   <= '0;
      tail_q  <= '0;
      tcnt_q  <= '0;
      tfe_q   <= 1'b0;
      lsp_q   <= 1'b0;
      fsp_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      val_q   <= '0;
      ls_q    <= 1'b0;
      le_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      tcnt_q  <= tcnt_d;
      tfe_q   <= tfe_d;
      lsp_q   <= lsp_d;
      fsp_q   <= fsp_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      val_q   <= val_d;
      ls_q    <= ls_d;
      le_q    <= le_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
    end
  end

  assign m_if.px_data     = dat_q;
  assign m_if.px_data_val = val_q;
  assign m_if.line_start  = ls_q;
  assign m_if.line_end    = le_q;
  assign m_if.frame_start = fs_q;
  assign m_if.frame_end   = fe_q;
  assign err_o            = err_q;
endmodule

// File: tb/tb_video_stream_repacker.sv
// Bench for video_stream_repacker: pixel-queue reference model, per-cycle compare, directed and random lines.
module tb_video_stream_repacker;
  localparam int W = 12;
  localparam int P = 4;
  typedef logic [P-1:0][W-1:0] word_t;
  typedef struct packed {
    word_t        d;
    logic [P-1:0] v;
    logic         ls, le, fs, fe;
  } word_s;

`ifdef VIDEO_STREAM_REPACKER_PAD_EN
  localparam logic [P-1:0] TM2 = 4'hF;
`else
  localparam logic [P-1:0] TM2 = 4'h3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;

  video_stream_repacker_if #(.PX_WIDTH(W), .PX_PER_CLK(P)) s_if ();
  video_stream_repacker_if #(.PX_WIDTH(W), .PX_PER_CLK(P)) m_if ();

  video_stream_repacker #(.PX_WIDTH(W), .PX_PER_CLK(P)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .s_if  (s_if),
    .m_if  (m_if),
    .err_o (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  word_s      exp_at [int];
  word_s      log_w [$];
  int         log_c [$];
  logic [W-1:0] q [$];
  bit         pls = 0, pfs = 0;
  int         tail_c = -100;
  int         err_from = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic word_s lw(input int i);
    if (i < log_w.size()) return log_w[i];
    return '0;
  endfunction

  function automatic int lc(input int i);
    if (i < log_c.size()) return log_c[i];
    return -1;
  endfunction

  // Reference model: a FIFO of pixels in arrival order, words cut from its head.
  task automatic emit(input int at, input int r, input bit le, input bit fe);
    word_s        w;
    logic [W-1:0] last;
    w = '0; last = '0;
    for (int j = 0; j < P; j++) begin
      if (j < r) begin
        w.d[j] = q.pop_front();
        last = w.d[j];
        w.v[j] = 1'b1;
      end else begin
`ifdef VIDEO_STREAM_REPACKER_PAD_EN
        w.d[j] = last;
        w.v[j] = 1'b1;
`endif
      end
    end
    w.ls = pls; w.fs = pfs; w.le = le; w.fe = fe;
    pls = 0; pfs = 0;
    exp_at[at] = w;
  endtask

  task automatic model_beat(input int c, input logic [P-1:0] m, input word_t d,
                            input bit ls, input bit le, input bit fs, input bit fe);
    int n;
    if (c == tail_c + 1) begin
      if (err_from < 0) err_from = c + 1;
      return;
    end
    if (ls || fs) pls = 1;
    if (fs) pfs = 1;
    for (int j = 0; j < P; j++) if (m[j]) q.push_back(d[j]);
    n = q.size();
    if (le) begin
      if (n > P) begin
        emit(c + 1, P, 0, 0);
        tail_c = c;
        emit(c + 2, n - P, 1, fe);
      end else emit(c + 1, n, 1, fe);
    end else if (n >= P) emit(c + 1, P, 0, 0);
  endtask

  task automatic model_reset();
    q.delete();
    pls = 0; pfs = 0;
    exp_at.delete();
    err_from = -1;
    tail_c = -100;
  endtask

  always @(negedge clk) begin
    word_s a;
    a.d = m_if.px_data; a.v = m_if.px_data_val;
    a.ls = m_if.line_start; a.le = m_if.line_end;
    a.fs = m_if.frame_start; a.fe = m_if.frame_end;
    if (!rst_n) begin
      chk("reset_outputs", 64'(a), 64'(0));
      chk("reset_err", 64'(err), 64'(0));
    end else begin
      if (a.v != 0) begin
        log_w.push_back(a);
        log_c.push_back(cyc);
      end
      if (exp_at.exists(cyc)) begin
        chk("word", 64'(a), 64'(exp_at[cyc]));
        exp_at.delete(cyc);
      end else chk("idle", 64'({a.v, a.ls, a.le, a.fs, a.fe}), 64'(0));
      chk("err", 64'(err), 64'(err_from >= 0 && cyc >= err_from));
    end
  end

  function automatic word_t pack(input logic [P-1:0] m, input int base);
    word_t d;
    int    k;
    k = base;
    for (int j = 0; j < P; j++) begin
      if (m[j]) begin
        d[j] = W'(k);
        k++;
      end else d[j] = 12'hABC;
    end
    return d;
  endfunction

  task automatic beat(input logic [P-1:0] m, input word_t d,
                      input bit ls, input bit le, input bit fs, input bit fe);
    @(posedge clk); #1;
    s_if.px_data = d;       s_if.px_data_val = m;
    s_if.line_start = ls;   s_if.line_end = le;
    s_if.frame_start = fs;  s_if.frame_end = fe;
    if (m != 0) model_beat(cyc, m, d, ls, le, fs, fe);
  endtask

  // Idle cycles carry random junk on data and markers, which must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_if.px_data = word_t'({$urandom, $urandom});
      s_if.px_data_val = '0;
      s_if.line_start = 1'($urandom); s_if.line_end = 1'($urandom);
      s_if.frame_start = 1'($urandom); s_if.frame_end = 1'($urandom);
    end
  endtask

  task automatic sparse_line();
    beat(4'b1110, pack(4'b1110, 0), 1, 0, 0, 0);
    beat(4'b1111, pack(4'b1111, 3), 0, 0, 0, 0);
    beat(4'b0111, pack(4'b0111, 7), 0, 1, 0, 0);
  endtask

  initial begin
    int b, c3;
    s_if.px_data = '0; s_if.px_data_val = '0;
    s_if.line_start = 0; s_if.line_end = 0; s_if.frame_start = 0; s_if.frame_end = 0;
    idle(3);
    @(posedge clk); #3 rst_n = 1'b1;
    idle(2);

    b = log_w.size();
    beat(4'hF, pack(4'hF, 0), 1, 0, 0, 0);
    beat(4'hF, pack(4'hF, 4), 0, 1, 0, 0);
    idle(3);
    chk("dense_count", 64'(log_w.size() - b), 64'(2));
    chk("dense_w0", 64'(lw(b).d), 64'h003002001000);
    chk("dense_w0_flags", 64'({lw(b).v, lw(b).ls, lw(b).le}), 64'({4'hF, 2'b10}));
    chk("dense_w1", 64'(lw(b+1).d), 64'h007006005004);
    chk("dense_w1_flags", 64'({lw(b+1).v, lw(b+1).ls, lw(b+1).le}), 64'({4'hF, 2'b01}));

    b = log_w.size();
    sparse_line();
    c3 = cyc;
    idle(3);
    chk("sparse_count", 64'(log_w.size() - b), 64'(3));
    chk("sparse_w0", 64'(lw(b).d), 64'h003002001000);
    chk("sparse_w1", 64'(lw(b+1).d), 64'h007006005004);
    chk("sparse_w1_le", 64'(lw(b+1).le), 64'(0));
`ifdef VIDEO_STREAM_REPACKER_PAD_EN
    chk("sparse_tail", 64'(lw(b+2).d), 64'h009009009008);
`else
    chk("sparse_tail", 64'(lw(b+2).d), 64'h000000009008);
`endif
    chk("sparse_tail_val", 64'({lw(b+2).v, lw(b+2).le}), 64'({TM2, 1'b1}));
    chk("sparse_tail_cyc", 64'(lc(b+2)), 64'(c3 + 2));

    b = log_w.size();
    beat(4'b0011, pack(4'b0011, 16), 1, 1, 1, 1);
    idle(2);
    chk("short_count", 64'(log_w.size() - b), 64'(1));
    chk("short_flags", 64'({lw(b).v, lw(b).ls, lw(b).le, lw(b).fs, lw(b).fe}), 64'({TM2, 4'hF}));

    b = log_w.size();
    for (int l = 0; l < 3; l++) begin
      beat(4'hF, pack(4'hF, l*8), 1, 0, l == 0, 0);
      beat(4'h3, pack(4'h3, l*8+4), 0, 1, 0, l == 2);
      idle(2);
    end
    chk("frame_count", 64'(log_w.size() - b), 64'(6));
    chk("frame_fs", 64'({lw(b).fs, lw(b+2).fs, lw(b+4).fs}), 64'(3'b100));
    chk("frame_fe", 64'({lw(b+1).fe, lw(b+3).fe, lw(b+5).fe}), 64'(3'b001));
    chk("frame_tails", 64'({lw(b+1).v, lw(b+3).v, lw(b+5).v}), 64'({TM2, TM2, TM2}));

    for (int ln = 0; ln < 250; ln++) begin
      int rem, pc;
      bit first;
      logic [P-1:0] m;
      rem = $urandom_range(1, 20);
      first = 1;
      while (rem > 0) begin
        do begin
          m = P'($urandom_range(1, (1 << P) - 1));
          pc = $countones(m);
        end while (pc > rem);
        rem -= pc;
        beat(m, word_t'({$urandom, $urandom}), first, rem == 0,
             first && (ln % 5 == 0), rem == 0 && (ln % 5 == 4));
        first = 0;
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(1 + $urandom_range(0, 1));
    end

    b = log_w.size();
    sparse_line();
    beat(4'hF, pack(4'hF, 64), 1, 0, 0, 0);
    idle(100);
    chk("viol_count", 64'(log_w.size() - b), 64'(3));
    chk("viol_tail_le", 64'(lw(b+2).le), 64'(1));
    chk("viol_err", 64'(err), 64'(1));

    beat(4'b0111, pack(4'b0111, 32), 1, 0, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset", 64'({m_if.px_data, m_if.px_data_val, m_if.line_start, m_if.line_end,
                            m_if.frame_start, m_if.frame_end, err}), 64'(0));
    idle(2);
    @(posedge clk); #3 rst_n = 1'b1;
    idle(1);
    b = log_w.size();
    beat(4'hF, pack(4'hF, 48), 1, 1, 0, 0);
    idle(3);
    chk("post_reset_count", 64'(log_w.size() - b), 64'(1));
    chk("post_reset_word", 64'(lw(b).d), 64'h033032031030);
    chk("post_reset_flags", 64'({lw(b).v, lw(b).ls, lw(b).le}), 64'({4'hF, 2'b11}));

    idle(3);
    chk("pending_words", 64'(exp_at.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
